// File: rtl/inst_fetch_unit.sv
// Instruction memory + PC: words are loaded while mode=0 and streamed out sequentially while mode=1.
// One-cycle fetch latency; stall freezes all fetch state, and redirect loads a new PC with a one-bubble flush.
module inst_fetch_unit #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int PC_W   = ADDR_W + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              stall,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] instr,
    output logic [PC_W-1:0]   instr_pc,
    output logic              instr_valid
);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]   instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        state_d       = mode ? ST_RUN : ST_LOAD;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        mem_d         = mem_q;

        // Fetching needs both the current and the sampled state to be RUN: this makes
        // the LOAD->RUN edge idle and a mode drop clear pc/valid on its own edge.
        if (state_q == ST_LOAD || !mode) begin
            pc_d          = '0;
            instr_valid_d = 1'b0;
        end else if (redirect) begin
            pc_d          = redirect_pc & ~PC_W'(3);
            instr_valid_d = 1'b0;
        end else if (!stall) begin
            instr_d       = mem_q[pc_q[PC_W-1:2]];
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + PC_W'(4);
        end

        // The fetch above reads mem_q, so a same-edge write is seen by the next fetch only.
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_LOAD;
            pc_q          <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            mem_q         <= '{default: '0};
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            mem_q         <= mem_d;
        end
    end

    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: drives a 32x32 and an 8x16 instance from shared stimulus,
// checked against a per-instance behavioural model.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        stall;
    logic        redirect;
    logic [6:0]  redirect_pc;

    logic [6:0]  pc0, instr_pc0;
    logic [31:0] instr0;
    logic        instr_valid0;
    logic [4:0]  pc1, instr_pc1;
    logic [15:0] instr1;
    logic        instr_valid1;

    always #5 clk = ~clk;

    inst_fetch_unit #(.DATA_W(32), .DEPTH(32)) dut0 (
        .clk(clk), .reset(reset), .mode(mode), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .pc(pc0), .instr(instr0), .instr_pc(instr_pc0), .instr_valid(instr_valid0)
    );

    inst_fetch_unit #(.DATA_W(16), .DEPTH(8)) dut1 (
        .clk(clk), .reset(reset), .mode(mode), .wr_en(wr_en),
        .wr_addr(wr_addr[2:0]), .wr_data(wr_data[15:0]), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc[4:0]),
        .pc(pc1), .instr(instr1), .instr_pc(instr_pc1), .instr_valid(instr_valid1)
    );

    // Observed outputs packed as {valid, instr_pc, pc, instr}, zero-extended for the small instance.
    logic [46:0] obs [2];
    assign obs[0] = {instr_valid0, instr_pc0, pc0, instr0};
    assign obs[1] = {instr_valid1, 2'b00, instr_pc1, 2'b00, pc1, 16'h0000, instr1};

    int tests_run = 0;
    int failures  = 0;

    // Behavioural model, one per instance.
    localparam int          DEP  [2] = '{32, 8};
    localparam logic [31:0] MASK [2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};
    logic [31:0] m_mem   [2][32];
    int          m_pc    [2];
    int          m_ipc   [2];
    logic [31:0] m_instr [2];
    logic        m_valid [2];
    logic        m_run   [2];

    function automatic void m_reset(int d);
        for (int i = 0; i < 32; i++) m_mem[d][i] = '0;
        m_pc[d] = 0; m_ipc[d] = 0; m_instr[d] = '0; m_valid[d] = 1'b0; m_run[d] = 1'b0;
    endfunction

    function automatic void m_edge(int d);
        int span;
        span = 4 * DEP[d];
        if (!mode || !m_run[d]) begin
            m_pc[d] = 0;
            m_valid[d] = 1'b0;
        end else if (redirect) begin
            m_pc[d] = ((int'(redirect_pc) % span) / 4) * 4;
            m_valid[d] = 1'b0;
        end else if (!stall) begin
            m_instr[d] = m_mem[d][m_pc[d] / 4];
            m_ipc[d]   = m_pc[d];
            m_valid[d] = 1'b1;
            m_pc[d]    = (m_pc[d] + 4) % span;
        end
        if (wr_en) m_mem[d][int'(wr_addr) % DEP[d]] = wr_data & MASK[d];
        m_run[d] = mode;
    endfunction

    function automatic logic [46:0] expv(int d);
        return {m_valid[d], 7'(m_ipc[d]), 7'(m_pc[d]), m_instr[d]};
    endfunction

    task automatic step();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!reset) m_reset(d);
            else m_edge(d);
        end
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; stall = 1'b0; redirect = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; mode = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        for (int d = 0; d < 2; d++) m_reset(d);
        #2;
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (obs[d] !== expv(d)) begin
                failures++;
                $display("FAIL reset_state dut%0d: got %h expected %h", d, obs[d], expv(d));
            end
        end
        step();
        reset = 1'b1;
    endtask

    task automatic test_load();
        mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'hA0 + 32'(i);
            stall = 1'(i % 2); redirect = 1'(i % 3 == 0); redirect_pc = 7'h24;
            step();
            for (int d = 0; d < 2; d++) begin
                tests_run++;
                if (obs[d] !== expv(d)) begin
                    failures++;
                    $display("FAIL load%0d dut%0d: got %h expected %h", i, d, obs[d], expv(d));
                end
            end
            tests_run++;
            if (pc0 !== 7'd0 || instr_valid0 !== 1'b0) begin
                failures++;
                $display("FAIL load_pc%0d: got pc=%h valid=%b expected pc=0 valid=0", i, pc0, instr_valid0);
            end
        end
        idle_inputs();
    endtask

    task automatic test_sequential();
        mode = 1'b1;
        step();
        tests_run++;
        if (instr_valid0 !== 1'b0 || pc0 !== 7'd0) begin
            failures++;
            $display("FAIL seq_idle_edge: got valid=%b pc=%h expected valid=0 pc=0", instr_valid0, pc0);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                tests_run++;
                if (obs[d] !== expv(d)) begin
                    failures++;
                    $display("FAIL seq%0d dut%0d: got %h expected %h", i, d, obs[d], expv(d));
                end
            end
            tests_run++;
            if (instr0 !== 32'hA0 + 32'(i) || instr_pc0 !== 7'(4*i) || pc0 !== 7'(4*i+4)) begin
                failures++;
                $display("FAIL seq_const%0d: got instr=%h ipc=%h pc=%h expected instr=%h ipc=%h pc=%h",
                         i, instr0, instr_pc0, pc0, 32'hA0 + 32'(i), 4*i, 4*i+4);
            end
        end
    endtask

    task automatic test_stall_redirect();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (instr0 !== 32'hA2 || pc0 !== 7'h0C || instr_valid0 !== 1'b1 || instr1 !== 16'hA2) begin
                failures++;
                $display("FAIL stall%0d: got instr=%h pc=%h valid=%b expected instr=a2 pc=0c valid=1", i, instr0, pc0, instr_valid0);
            end
        end
        stall = 1'b0; redirect = 1'b1; redirect_pc = 7'h15;
        step();
        redirect = 1'b0;
        tests_run++;
        if (pc0 !== 7'h14 || instr_valid0 !== 1'b0 || pc1 !== 5'h14) begin
            failures++;
            $display("FAIL redirect_bubble: got pc=%h valid=%b expected pc=14 valid=0", pc0, instr_valid0);
        end
        step();
        tests_run++;
        if (instr0 !== 32'hA5 || instr_pc0 !== 7'h14 || instr_valid0 !== 1'b1) begin
            failures++;
            $display("FAIL redirect_target: got instr=%h ipc=%h valid=%b expected instr=a5 ipc=14 valid=1", instr0, instr_pc0, instr_valid0);
        end
        stall = 1'b1; redirect = 1'b1; redirect_pc = 7'h08;
        step();
        idle_inputs();
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (obs[d] !== expv(d)) begin
                failures++;
                $display("FAIL stall_and_redirect dut%0d: got %h expected %h", d, obs[d], expv(d));
            end
        end
        step();
        tests_run++;
        if (instr0 !== 32'hA2 || instr_pc0 !== 7'h08) begin
            failures++;
            $display("FAIL redirect_wins: got instr=%h ipc=%h expected instr=a2 ipc=08", instr0, instr_pc0);
        end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 7'h7C;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                tests_run++;
                if (obs[d] !== expv(d)) begin
                    failures++;
                    $display("FAIL wrap%0d dut%0d: got %h expected %h", i, d, obs[d], expv(d));
                end
            end
        end
        tests_run++;
        if (instr0 !== 32'hA1 || instr_pc0 !== 7'h04 || pc0 !== 7'h08) begin
            failures++;
            $display("FAIL wrap_const: got instr=%h ipc=%h pc=%h expected instr=a1 ipc=04 pc=08", instr0, instr_pc0, pc0);
        end
    endtask

    task automatic test_read_during_write();
        redirect = 1'b1; redirect_pc = 7'h0C;
        step();
        redirect = 1'b0; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_DEAD;
        step();
        wr_en = 1'b0;
        tests_run++;
        if (instr0 !== 32'hA3 || instr1 !== 16'hA3) begin
            failures++;
            $display("FAIL rdw_old: got instr=%h/%h expected a3", instr0, instr1);
        end
        redirect = 1'b1;
        step();
        redirect = 1'b0;
        step();
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (obs[d] !== expv(d)) begin
                failures++;
                $display("FAIL rdw_new dut%0d: got %h expected %h", d, obs[d], expv(d));
            end
        end
        tests_run++;
        if (instr0 !== 32'h0000_DEAD || instr1 !== 16'hDEAD) begin
            failures++;
            $display("FAIL rdw_new_const: got instr=%h/%h expected dead", instr0, instr1);
        end
    endtask

    task automatic test_mode_drop_and_async_reset();
        mode = 1'b0;
        step();
        tests_run++;
        if (pc0 !== 7'd0 || instr_valid0 !== 1'b0 || pc1 !== 5'd0 || instr_valid1 !== 1'b0) begin
            failures++;
            $display("FAIL mode_drop: got pc=%h valid=%b expected pc=0 valid=0", pc0, instr_valid0);
        end
        mode = 1'b1;
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (obs[d] !== expv(d)) begin
                failures++;
                $display("FAIL rerun_from0 dut%0d: got %h expected %h", d, obs[d], expv(d));
            end
        end
        step();
        #2;
        reset = 1'b0;
        for (int d = 0; d < 2; d++) m_reset(d);
        #1;
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (obs[d] !== expv(d)) begin
                failures++;
                $display("FAIL async_reset dut%0d: got %h expected %h", d, obs[d], expv(d));
            end
        end
        step();
        reset = 1'b1;
        step();
        step();
        step();
        tests_run++;
        if (instr0 !== 32'd0 || instr_valid0 !== 1'b1 || instr_pc0 !== 7'h04 || instr1 !== 16'd0) begin
            failures++;
            $display("FAIL mem_cleared: got instr=%h valid=%b ipc=%h expected instr=0 valid=1 ipc=04", instr0, instr_valid0, instr_pc0);
        end
    endtask

    task automatic test_random();
        int mismatches;
        mismatches = 0;
        for (int i = 0; i < 600; i++) begin
            mode        = ($urandom_range(0, 19) != 0);
            wr_en       = ($urandom_range(0, 2) == 0);
            wr_addr     = 5'($urandom);
            wr_data     = $urandom;
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 7) == 0);
            redirect_pc = 7'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #2;
                reset = 1'b0;
                for (int d = 0; d < 2; d++) m_reset(d);
                #1;
                for (int d = 0; d < 2; d++) begin
                    tests_run++;
                    if (obs[d] !== expv(d)) begin
                        failures++;
                        $display("FAIL rand_async_reset%0d dut%0d: got %h expected %h", i, d, obs[d], expv(d));
                    end
                end
                reset = 1'b1;
            end
            step();
            for (int d = 0; d < 2; d++) begin
                tests_run++;
                if (obs[d] !== expv(d)) begin
                    failures++;
                    mismatches++;
                    if (mismatches <= 10)
                        $display("FAIL rand%0d dut%0d: got %h expected %h", i, d, obs[d], expv(d));
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load();
        test_sequential();
        test_stall_redirect();
        test_wrap();
        test_read_during_write();
        test_mode_drop_and_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
